// File: rtl/wb_sram_bridges_pkg.sv
// Shared definitions for the SRAM <-> Wishbone bridge family: the master
// bridge state encoding and the word-address to byte-address shift used
// when building or slicing the Wishbone ADR field.
package wb_sram_bridges_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUS  = 1'b1
   } wb_master_bridge_state_e;

   // Number of low ADR bits below the SRAM word address for a given data width
   function automatic int adr_byte_shift(input int data_width);
      return (data_width / 32) + 1;
   endfunction

endpackage

// File: rtl/generic_sram_byte_en_if.sv
// Generic byte-enable SRAM port. The bridge acts as the memory (sram
// modport); the client drives address, enables and write data.
interface generic_sram_byte_en_if #(
   parameter int ADDRESS_WIDTH = 10,
   parameter int DATA_WIDTH    = 32
);

   logic [ADDRESS_WIDTH-1:0]  addr;
   logic                      read_en;
   logic                      write_en;
   logic [DATA_WIDTH/8-1:0]   byte_en;
   logic [DATA_WIDTH-1:0]     write_data;
   logic [DATA_WIDTH-1:0]     read_data;

   modport sram (
      input  addr, read_en, write_en, byte_en, write_data,
      output read_data
   );

   modport client (
      output addr, read_en, write_en, byte_en, write_data,
      input  read_data
   );

endinterface

// File: rtl/wb_if.sv
// Wishbone classic bus bundle with master and slave views, including the
// optional cycle/burst type and tag signals.
interface wb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);

   logic                     cyc;
   logic                     stb;
   logic                     we;
   logic [DATA_WIDTH/8-1:0]  sel;
   logic [ADDR_WIDTH-1:0]    adr;
   logic [DATA_WIDTH-1:0]    dat_w;
   logic [DATA_WIDTH-1:0]    dat_r;
   logic                     ack;
   logic                     err;
   logic [2:0]               cti;
   logic [1:0]               bte;
   logic                     tga;
   logic                     tgc;
   logic                     tgd_w;

   modport master (
      output cyc, stb, we, sel, adr, dat_w, cti, bte, tga, tgc, tgd_w,
      input  dat_r, ack, err
   );

   modport slave (
      input  cyc, stb, we, sel, adr, dat_w, cti, bte, tga, tgc, tgd_w,
      output dat_r, ack, err
   );

endinterface

// File: rtl/generic_byte_en_sram_wb_master_bridge.sv
// Presents an SRAM-style responder port to a client and turns each accepted
// access into one Wishbone classic master cycle. Since the SRAM side has no
// wait signal, the client is stalled with busy and told about completed reads
// with an rvalid pulse; bus errors and timeouts raise a one-cycle err pulse.
module generic_byte_en_sram_wb_master_bridge
   import wb_sram_bridges_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int WB_ADDR_WIDTH  = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                 clk,
   input  logic                 rstn,
   generic_sram_byte_en_if.sram sram_s,
   wb_if.master                 wb_m,
   output logic                 busy,
   output logic                 rvalid,
   output logic                 err
);

   localparam int BE_WIDTH  = DATA_WIDTH / 8;
   localparam int ADR_SHIFT = adr_byte_shift(DATA_WIDTH);
   localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   wb_master_bridge_state_e  state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [BE_WIDTH-1:0]      be_q, be_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic                     we_q, we_d;
   logic [CNT_WIDTH-1:0]     count_q, count_d;
   logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
   logic                     rvalid_q, rvalid_d;
   logic                     err_q, err_d;
   logic                     timeout_hit;

   // Accept a request in IDLE, then hold the bus until ACK, ERR or timeout
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      count_d     = count_q;
      read_data_d = read_data_q;
      rvalid_d    = 1'b0;
      err_d       = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (sram_s.read_en || sram_s.write_en) begin
               state_d = BUS;
               addr_d  = sram_s.addr;
               be_d    = sram_s.byte_en;
               wdata_d = sram_s.write_data;
               we_d    = sram_s.write_en;
               count_d = '0;
            end
         end
         BUS: begin
            timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == CNT_LAST);
            if (wb_m.ack) begin
               state_d = IDLE;
               if (!we_q) begin
                  read_data_d = wb_m.dat_r;
                  rvalid_d    = 1'b1;
               end
            end else if (wb_m.err || timeout_hit) begin
               state_d = IDLE;
               err_d   = 1'b1;
               if (!we_q) begin
                  read_data_d = '0;
                  rvalid_d    = 1'b1;
               end
            end else begin
               count_d = count_q + CNT_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, captured request, timeout counter and client-side result registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         count_q     <= '0;
         read_data_q <= '0;
         rvalid_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         count_q     <= count_d;
         read_data_q <= read_data_d;
         rvalid_q    <= rvalid_d;
         err_q       <= err_d;
      end
   end

   assign busy             = (state_q == BUS);
   assign rvalid           = rvalid_q;
   assign err              = err_q;
   assign sram_s.read_data = read_data_q;

   assign wb_m.cyc   = busy;
   assign wb_m.stb   = busy;
   assign wb_m.we    = we_q;
   assign wb_m.sel   = be_q;
   assign wb_m.adr   = WB_ADDR_WIDTH'(addr_q) << ADR_SHIFT;
   assign wb_m.dat_w = wdata_q;
   assign wb_m.cti   = 3'b000;
   assign wb_m.bte   = 2'b00;
   assign wb_m.tga   = 1'b0;
   assign wb_m.tgc   = 1'b0;
   assign wb_m.tgd_w = 1'b0;

endmodule

// File: tb/tb_generic_byte_en_sram_wb_master_bridge.sv
// Scoreboard bench for the SRAM-to-Wishbone master bridge. Directed requests
// push the expected bus cycle, stall length and client response; a monitor on
// the falling clock edge pops and compares whenever the DUT shows them.
module tb_generic_byte_en_sram_wb_master_bridge;

   typedef enum int {S_NORMAL, S_ERR, S_BOTH, S_NORESP} slave_mode_e;

   typedef struct packed {
      logic [31:0] adr;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] dat;
   } bus_t;

   typedef struct packed {
      logic        rv;
      logic        er;
      logic [31:0] data;
   } resp_t;

   logic clk;
   logic rstn;
   logic busy, rvalid, err;
   logic busy64, rvalid64, err64;

   generic_sram_byte_en_if #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32)) sram_if ();
   wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb_bus ();
   generic_sram_byte_en_if #(.ADDRESS_WIDTH(10), .DATA_WIDTH(64)) sram64 ();
   wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) wb64 ();

   generic_byte_en_sram_wb_master_bridge #(
      .ADDRESS_WIDTH(10), .DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rstn(rstn), .sram_s(sram_if.sram), .wb_m(wb_bus.master),
      .busy(busy), .rvalid(rvalid), .err(err)
   );

   generic_byte_en_sram_wb_master_bridge #(
      .ADDRESS_WIDTH(10), .DATA_WIDTH(64), .WB_ADDR_WIDTH(32), .TIMEOUT_CYCLES(256)
   ) dut64 (
      .clk(clk), .rstn(rstn), .sram_s(sram64.sram), .wb_m(wb64.master),
      .busy(busy64), .rvalid(rvalid64), .err(err64)
   );

   int n_checks = 0;
   int n_fail   = 0;

   bus_t  exp_bus[$];
   int    exp_busy[$];
   resp_t exp_resp[$];

   slave_mode_e mode = S_NORMAL;
   int          wait_states = 0;
   int          wcnt = 0;
   logic [31:0] mem [0:1023];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wishbone slave model for the 32-bit DUT: programmable wait states and response kind
   assign wb_bus.ack   = wb_bus.cyc && wb_bus.stb && (wcnt == wait_states) &&
                         (mode == S_NORMAL || mode == S_BOTH);
   assign wb_bus.err   = wb_bus.cyc && wb_bus.stb && (wcnt == wait_states) &&
                         (mode == S_ERR || mode == S_BOTH);
   assign wb_bus.dat_r = mem[wb_bus.adr[11:2]];

   // Zero-wait slave for the 64-bit DUT returning a fixed pattern
   assign wb64.ack   = wb64.cyc && wb64.stb;
   assign wb64.err   = 1'b0;
   assign wb64.dat_r = 64'h0102_0304_0506_0708;

   // Slave wait-state counter and byte-lane memory writes
   always @(posedge clk) begin
      if (wb_bus.cyc && wb_bus.stb && !(wb_bus.ack || wb_bus.err))
         wcnt <= wcnt + 1;
      else
         wcnt <= 0;
      if (wb_bus.ack && wb_bus.we) begin
         for (int b = 0; b < 4; b++)
            if (wb_bus.sel[b])
               mem[wb_bus.adr[11:2]][8*b +: 8] <= wb_bus.dat_w[8*b +: 8];
      end
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   logic cyc_prev  = 1'b0;
   logic busy_prev = 1'b0;
   int   busy_len  = 0;

   // Monitor: compare bus cycle start, stall length and client responses against the queues
   always @(negedge clk) begin
      bus_t  eb;
      resp_t er;
      if (wb_bus.cyc && !cyc_prev) begin
         if (exp_bus.size() == 0) begin
            check_output("bus_unexpected_cycle", {32'h0, wb_bus.adr}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            eb = exp_bus.pop_front();
            check_output("bus_adr", wb_bus.adr, eb.adr);
            check_output("bus_sel", wb_bus.sel, eb.sel);
            check_output("bus_we", wb_bus.we, eb.we);
            check_output("bus_dat_w", wb_bus.dat_w, eb.dat);
            check_output("bus_stb", wb_bus.stb, 1);
            check_output("bus_tags", {wb_bus.cti, wb_bus.bte, wb_bus.tga, wb_bus.tgc, wb_bus.tgd_w}, 0);
         end
      end
      if (busy) begin
         busy_len = busy_len + 1;
      end else if (busy_prev) begin
         if (exp_busy.size() == 0)
            check_output("busy_unexpected", busy_len, 0);
         else
            check_output("busy_len", busy_len, exp_busy.pop_front());
         busy_len = 0;
      end
      if (rvalid || err) begin
         if (exp_resp.size() == 0) begin
            check_output("resp_unexpected", {rvalid, err}, 0);
         end else begin
            er = exp_resp.pop_front();
            check_output("resp_rvalid", rvalid, er.rv);
            check_output("resp_err", err, er.er);
            check_output("resp_read_data", sram_if.read_data, er.data);
            check_output("resp_after_bus", busy_prev, 1);
            check_output("resp_cyc_low", wb_bus.cyc, 0);
         end
      end
      cyc_prev  = wb_bus.cyc;
      busy_prev = busy;
   end

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (busy) check_output("idle_wait_expired", busy, 0);
   endtask

   task automatic apply_stimulus(
      input bit          rd,
      input bit          wr,
      input logic [9:0]  a,
      input logic [3:0]  be,
      input logic [31:0] d,
      input int          waits,
      input slave_mode_e m,
      input logic [31:0] exp_adr,
      input int          exp_busy_len,
      input bit          exp_rv,
      input bit          exp_er,
      input logic [31:0] exp_data,
      input bit          wait_done
   );
      bus_t  eb;
      resp_t er;
      wait_idle();
      @(negedge clk);
      mode        = m;
      wait_states = waits;
      sram_if.addr       = a;
      sram_if.byte_en    = be;
      sram_if.write_data = d;
      sram_if.read_en    = rd;
      sram_if.write_en   = wr;
      eb.adr = exp_adr;
      eb.sel = be;
      eb.we  = wr;
      eb.dat = d;
      exp_bus.push_back(eb);
      exp_busy.push_back(exp_busy_len);
      if (exp_rv || exp_er) begin
         er.rv   = exp_rv;
         er.er   = exp_er;
         er.data = exp_data;
         exp_resp.push_back(er);
      end
      @(posedge clk);
      #1;
      sram_if.read_en  = 1'b0;
      sram_if.write_en = 1'b0;
      if (wait_done) begin
         wait_idle();
         repeat (2) @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus_t  eb;
      resp_t er;
      int    k;
      rstn = 1'b0;
      sram_if.addr = '0; sram_if.byte_en = '0; sram_if.write_data = '0;
      sram_if.read_en = 1'b0; sram_if.write_en = 1'b0;
      sram64.addr = '0; sram64.byte_en = '0; sram64.write_data = '0;
      sram64.read_en = 1'b0; sram64.write_en = 1'b0;
      #3;
      check_output("reset_busy", busy, 0);
      check_output("reset_cyc_stb", {wb_bus.cyc, wb_bus.stb}, 0);
      check_output("reset_we_sel", {wb_bus.we, wb_bus.sel}, 0);
      check_output("reset_adr", wb_bus.adr, 0);
      check_output("reset_dat_w", wb_bus.dat_w, 0);
      check_output("reset_read_data", sram_if.read_data, 0);
      check_output("reset_rvalid_err", {rvalid, err}, 0);
      #9;
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // Zero-wait full write to word 5
      apply_stimulus(0, 1, 10'h005, 4'hF, 32'hA5A5_1234, 0, S_NORMAL, 32'h14, 1, 0, 0, 0, 1);
      check_output("mem_word5", mem[5], 32'hA5A5_1234);
      // Read back with 3 wait states
      apply_stimulus(1, 0, 10'h005, 4'hF, 32'h0, 3, S_NORMAL, 32'h14, 4, 1, 0, 32'hA5A5_1234, 1);
      // Partial write of byte lane 1 then read
      apply_stimulus(0, 1, 10'h005, 4'h2, 32'h0000_BB00, 1, S_NORMAL, 32'h14, 2, 0, 0, 0, 1);
      apply_stimulus(1, 0, 10'h005, 4'hF, 32'h0, 0, S_NORMAL, 32'h14, 1, 1, 0, 32'hA5A5_BB34, 1);
      // Highest word address, upper lanes only; read_data must not change on a write
      apply_stimulus(0, 1, 10'h3FF, 4'hC, 32'h1234_5678, 2, S_NORMAL, 32'hFFC, 3, 0, 0, 0, 1);
      check_output("rdata_hold_after_write", sram_if.read_data, 32'hA5A5_BB34);
      // Slave error on a read
      apply_stimulus(1, 0, 10'h005, 4'hF, 32'h0, 0, S_ERR, 32'h14, 1, 1, 1, 32'h0, 1);
      // Both enables high: treated as a write to the lower lanes
      apply_stimulus(1, 1, 10'h3FF, 4'h3, 32'h0000_ABCD, 0, S_NORMAL, 32'hFFC, 1, 0, 0, 0, 1);
      apply_stimulus(1, 0, 10'h3FF, 4'hF, 32'h0, 1, S_NORMAL, 32'hFFC, 2, 1, 0, 32'h1234_ABCD, 1);
      // ACK and ERR together: ACK wins
      apply_stimulus(1, 0, 10'h005, 4'hF, 32'h0, 0, S_BOTH, 32'h14, 1, 1, 0, 32'hA5A5_BB34, 1);

      // Silent slave: timeout after 8 bus cycles; a request while busy is ignored
      apply_stimulus(1, 0, 10'h005, 4'hF, 32'h0, 0, S_NORESP, 32'h14, 8, 1, 1, 32'h0, 0);
      repeat (2) @(negedge clk);
      sram_if.addr = 10'h009; sram_if.byte_en = 4'hF;
      sram_if.write_data = 32'hFFFF_FFFF; sram_if.write_en = 1'b1;
      @(posedge clk);
      #1;
      sram_if.write_en = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      check_output("mem_word9_untouched", {31'h0, mem[9] === 32'hFFFF_FFFF}, 0);

      // Request held through completion is accepted twice, back to back
      @(negedge clk);
      mode = S_NORMAL; wait_states = 0;
      sram_if.addr = 10'h005; sram_if.byte_en = 4'hF; sram_if.write_data = '0;
      sram_if.read_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         eb.adr = 32'h14; eb.sel = 4'hF; eb.we = 1'b0; eb.dat = 32'h0;
         exp_bus.push_back(eb);
         exp_busy.push_back(1);
         er.rv = 1'b1; er.er = 1'b0; er.data = 32'hA5A5_BB34;
         exp_resp.push_back(er);
      end
      repeat (3) @(posedge clk);
      #1;
      sram_if.read_en = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      // Reset in the middle of a bus cycle
      apply_stimulus(1, 0, 10'h005, 4'hF, 32'h0, 0, S_NORESP, 32'h14, 3, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check_output("midreset_cyc_stb", {wb_bus.cyc, wb_bus.stb}, 0);
      check_output("midreset_busy", busy, 0);
      check_output("midreset_read_data", sram_if.read_data, 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      mode = S_NORMAL;
      repeat (2) @(negedge clk);
      apply_stimulus(0, 1, 10'h007, 4'hF, 32'hDEAD_BEEF, 0, S_NORMAL, 32'h1C, 1, 0, 0, 0, 1);
      apply_stimulus(1, 0, 10'h007, 4'hF, 32'h0, 0, S_NORMAL, 32'h1C, 1, 1, 0, 32'hDEAD_BEEF, 1);

      // 64-bit data path: word 3 maps to byte address 0x18
      @(negedge clk);
      sram64.addr = 10'h003; sram64.byte_en = 8'hFF;
      sram64.write_data = 64'h1122_3344_5566_7788; sram64.write_en = 1'b1;
      @(posedge clk);
      #1;
      sram64.write_en = 1'b0;
      @(negedge clk);
      check_output("dw64_cyc", wb64.cyc, 1);
      check_output("dw64_adr", wb64.adr, 32'h18);
      check_output("dw64_sel_we", {wb64.sel, wb64.we}, 9'h1FF);
      check_output("dw64_dat_w", wb64.dat_w, 64'h1122_3344_5566_7788);
      check_output("dw64_tags", {wb64.cti, wb64.bte, wb64.tga, wb64.tgc, wb64.tgd_w}, 0);
      @(negedge clk);
      check_output("dw64_busy_done", busy64, 0);
      sram64.read_en = 1'b1;
      @(posedge clk);
      #1;
      sram64.read_en = 1'b0;
      k = 0;
      while (!rvalid64 && k < 10) begin
         @(negedge clk);
         k++;
      end
      check_output("dw64_rvalid", {rvalid64, err64}, 2'b10);
      check_output("dw64_read_data", sram64.read_data, 64'h0102_0304_0506_0708);

      repeat (4) @(negedge clk);
      check_output("bus_queue_drained", exp_bus.size(), 0);
      check_output("busy_queue_drained", exp_busy.size(), 0);
      check_output("resp_queue_drained", exp_resp.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/generic_byte_en_sram_wb_master_bridge.md
# generic_byte_en_sram_wb_master_bridge

Reverse of the Wishbone-slave-to-SRAM bridge. It presents a generic byte-enable SRAM *responder* port to an SRAM-style client (CPU local port, DMA, test driver) and turns each accepted access into a single Wishbone classic master cycle. Because Wishbone latency is unbounded and the SRAM interface has no wait signal, the block adds a `busy` stall output and a `rvalid` strobe. It sits between an SRAM-style client and a Wishbone interconnect master port.

## Interface
- `ADDRESS_WIDTH`, 10: SRAM word-address width.
- `DATA_WIDTH`, 32: data width, 32 or 64; byte-enable width is `DATA_WIDTH/8`.
- `WB_ADDR_WIDTH`, 32: Wishbone `ADR` width; must be ≥ `ADDRESS_WIDTH+(DATA_WIDTH/32)+1`.
- `TIMEOUT_CYCLES`, 256: cycles to wait for `ACK`/`ERR` before abandoning a cycle; 0 disables the timeout.
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset; one clock, asynchronous, active-low.
- `sram_s`  `generic_sram_byte_en_if.sram`  responder port: `addr`, `read_en`, `write_en`, `byte_en`, `write_data` in; `read_data` out.
- `wb_m`  `wb_if.master`  Wishbone classic master.
- `busy`  out  1  high while a request is outstanding; the client must hold off new requests.
- `rvalid`  out  1  one-cycle pulse when `read_data` is updated for a completed read.
- `err`  out  1  one-cycle pulse on `ERR` or timeout.

## Operation
- States: `IDLE`, `BUS`.
- **Request acceptance:** in `IDLE`, the bridge samples `read_en|write_en` at the clock edge.
  - An accepted request captures `addr`, `byte_en`, `write_data` and direction into registers, then moves to `BUS`.
  - `write_en` wins when both enables are high (treated as a write).
- **`BUS` state:**
  - Drives `CYC=STB=1`, `WE` = captured direction, `SEL` = captured `byte_en`, `DAT_W` = captured data.
  - `ADR` = `{zeros, addr, (DATA_WIDTH/32)+1 zero bits}`, the exact inverse of the slave bridge's address slice.
  - Holds these values until `ACK`, `ERR` or timeout.
- **On `ACK`:**
  - Return to `IDLE`.
  - For a read, load `read_data` ← `DAT_R` and pulse `rvalid`.
- **On `ERR`:**
  - Return to `IDLE` and pulse `err`.
  - For a read, load `read_data` ← 0 and pulse `rvalid`.
- **Timeout:**
  - The counter clears on entry to `BUS` and increments each `BUS` cycle without `ACK`/`ERR`.
  - When `count == TIMEOUT_CYCLES-1` and still no response: drop `CYC`/`STB`, return to `IDLE`, pulse `err`; for a read also load `read_data` ← 0 and pulse `rvalid`.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- **Priority:** `ACK` beats `ERR` if both are high; either beats timeout in the same cycle.
- **Status and tags:**
  - `busy` = (state == `BUS`).
  - Requests presented while `busy` are ignored, not queued.
  - `TGA`/`TGC`/`TGD_W` driven 0; `CTI`=0, `BTE`=0 where present.
- **Reset values (async):** state `IDLE`, `CYC=STB=WE=0`, `SEL=0`, `ADR=0`, `DAT_W=0`, `read_data=0`, `busy=0`, `rvalid=0`, `err=0`, counter 0.
  - Reset mid-cycle drops `CYC`/`STB` immediately.

## Timing
- Request sampled at edge E0; `CYC`/`STB` high from E0 onward.
- Zero-wait slave (`ACK` in the first `STB` cycle): completion at E1; `busy` high for exactly 1 cycle; `rvalid` and new `read_data` in the cycle after E1.
- N-wait-state slave: `busy` high for N+1 cycles.
- Throughput limit: one access per 2 cycles, since `IDLE` is mandatory between accesses.
- A request held high through completion is re-accepted as a new access in the `IDLE` cycle; clients must deassert enables once accepted.
- `read_data` holds its value until the next read completes; writes never alter it.

## Structure
- Shared package `wb_sram_bridges_pkg`: state enum `wb_master_bridge_state_e {IDLE, BUS}` and a function computing the `ADR` byte-offset shift `(DATA_WIDTH/32)+1`, reused by both bridge directions.
- No sub-module. The timeout counter is small enough to stay inline.

## Test plan
- Zero-wait slave; write `addr=0x005`, `byte_en=0xF`, `data=0xA5A5_1234` -> `ADR=0x14`, `SEL=0xF`, `WE=1`; `busy` high 1 cycle; memory holds `0xA5A5_1234`.
- Read back `addr=0x005` with 3 wait states -> `busy` high 4 cycles, `rvalid` pulses once, `read_data=0xA5A5_1234`.
- Partial write `byte_en=0x2`, `data=0x0000_BB00` then read -> `0xA5A5_BB34`; `DATA_WIDTH=64` with `addr=3` -> `ADR=0x18`.
- Slave asserts `ERR` on a read -> `err` and `rvalid` pulse together, `read_data=0`, `CYC` low next cycle.
- Slave never responds, `TIMEOUT_CYCLES=8` -> `CYC` drops after 8 `BUS` cycles, `err` pulses; a request issued while `busy` produces no Wishbone cycle.
- `rstn` asserted mid-`BUS` -> `CYC`/`STB`/`busy` low without waiting for a clock edge; the first request after release completes normally.
